// File: rtl/desc_fifo_pkg.sv
// desc_fifo_pkg: shared widths and pointer-compare helpers for the descriptor queue
package desc_fifo_pkg;
  localparam int DESC_W = 11;
  localparam int DESC_AW = 2;
  localparam string STATS_MACRO = "DESC_FIFO_STATS_EN";
  function automatic logic ptr_empty(input logic [15:0] a, input logic [15:0] b);
    return a == b;
  endfunction
  function automatic logic ptr_full(input logic [15:0] a, input logic [15:0] b, input int unsigned aw);
    return (a ^ b) == (16'd1 << aw);
  endfunction
endpackage

// File: rtl/desc_ram_2p.sv
// desc_ram_2p: dual-port distributed RAM, registered write, asynchronous read
module desc_ram_2p
  import desc_fifo_pkg::*;
#(
  parameter int D_WIDTH = DESC_W,
  parameter int A_WIDTH = DESC_AW
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);
  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/desc_fifo_reader.sv
// desc_fifo_reader: descriptor queue with registered valid/ready output stage; DESC_FIFO_STATS_EN adds drop_cnt/level
module desc_fifo_reader
  import desc_fifo_pkg::*;
#(
  parameter int D_WIDTH = DESC_W,
  parameter int A_WIDTH = DESC_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  output logic               wr_full,
  output logic               wr_ovf,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_empty
`ifdef DESC_FIFO_STATS_EN
  ,
  output logic [15:0]        drop_cnt,
  output logic [A_WIDTH+1:0] level
`endif
);
  logic [A_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [D_WIDTH-1:0] ram_q;
  logic ram_empty, wr_acc, load;
  assign ram_empty = ptr_empty(16'(wr_ptr), 16'(rd_ptr));
  assign wr_acc = wr_en & ~wr_full;
  // load decision uses pre-edge ram_empty: no write-to-read bypass
  assign load = ~ram_empty & (~rd_valid | rd_ready);
  assign wr_ptr_nxt = wr_ptr + {{A_WIDTH{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{A_WIDTH{1'b0}}, load};
  assign rd_empty = ram_empty & ~rd_valid;
  desc_ram_2p #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[A_WIDTH-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[A_WIDTH-1:0]),
    .rdata(ram_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_full  <= 1'b0;
      wr_ovf   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_full  <= ptr_full(16'(wr_ptr_nxt), 16'(rd_ptr_nxt), A_WIDTH);
      wr_ovf   <= wr_en & wr_full;
      rd_valid <= load ? 1'b1 : (rd_ready & ram_empty) ? 1'b0 : rd_valid;
      rd_data  <= load ? ram_q : rd_data;
    end
`ifdef DESC_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (wr_en & wr_full & (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  assign level = {1'b0, wr_ptr - rd_ptr} + {{(A_WIDTH+1){1'b0}}, rd_valid};
`endif
endmodule

// File: tb/tb_desc_fifo_reader.sv
// tb_desc_fifo_reader: scoreboard bench for desc_fifo_reader (honours DESC_FIFO_STATS_EN)
module tb_desc_fifo_reader;
  localparam int DW = 11;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_full, wr_ovf, rd_valid, rd_empty;
  logic [DW-1:0] rd_data;
  int errors = 0, checks = 0;
  int m_cnt = 0, m_drop = 0, n_in = 0, n_out = 0;
  logic m_v = 1'b0, m_full = 1'b0, m_ovf = 1'b0;
  logic [DW-1:0] sb[$];
`ifdef DESC_FIFO_STATS_EN
  logic [15:0] drop_cnt;
  logic [AW+1:0] level;
`endif
  desc_fifo_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .wr_ovf(wr_ovf), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_empty(rd_empty)
`ifdef DESC_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .level(level)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_v = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_drop = 0;
    sb.delete();
  endtask
  task automatic step();
    logic acc, ld;
    chk("rd_valid", rd_valid, m_v);
    chk("wr_full", wr_full, m_full);
    chk("wr_ovf", wr_ovf, m_ovf);
    chk("rd_empty", rd_empty, (m_cnt == 0) && !m_v);
    if (m_v && sb.size() > 0) chk("rd_data", rd_data, sb[0]);
`ifdef DESC_FIFO_STATS_EN
    chk("drop_cnt", drop_cnt, m_drop);
    chk("level", level, m_cnt + m_v);
`endif
    if (rd_valid && rd_ready) n_out++;
    acc = wr_en && !m_full;
    ld = (m_cnt > 0) && (!m_v || rd_ready);
    if (m_v && rd_ready && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin sb.push_back(wr_data); n_in++; end
    if (wr_en && m_full && m_drop < 16'hFFFF) m_drop++;
    m_ovf = wr_en && m_full;
    m_cnt = m_cnt + int'(acc) - int'(ld);
    m_v = ld || (m_v && !rd_ready);
    m_full = (m_cnt == DEPTH);
    @(posedge clk); #1;
  endtask
  task automatic drive(input logic we, input logic [DW-1:0] d, input logic rr);
    wr_en = we; wr_data = d; rd_ready = rr;
    step();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset rd_data", rd_data, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1);
    chk("idle rd_data", rd_data, 0);
    drive(0, 0, 1);
    drive(1, 11'h5A3, 1);
    drive(0, 0, 1);
    chk("single out", rd_data, 11'h5A3);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    for (int i = 1; i <= 6; i++) drive(1, DW'(i), 0);
    chk("fill ovf", wr_ovf, 1);
`ifdef DESC_FIFO_STATS_EN
    chk("fill drop_cnt", drop_cnt, 1);
`endif
    for (int i = 0; i < 8; i++) drive(0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, DW'(11'h10 + i), 0);
    drive(1, 11'h7FF, 1);
    chk("pop+write full", wr_full, 0);
    drive(1, 11'h7FF, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1);
    chk("last out", rd_data, 11'h7FF);
    n_in = 0; n_out = 0;
    for (int i = 0; i < 200; i++) drive(!m_full, DW'(11'h100 + n_in), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) drive(0, 0, 1);
    chk("stream count", n_out, n_in);
    chk("stream wraps", n_in >= 6 * DEPTH, 1);
    for (int i = 0; i < 3; i++) drive(1, DW'(11'h20 + i), 0);
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst rd_valid", rd_valid, 0);
    chk("arst wr_full", wr_full, 0);
    chk("arst rd_empty", rd_empty, 1);
    chk("arst rd_data", rd_data, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 11'h001, 0);
    drive(0, 0, 0);
    chk("post-reset first", rd_data, 11'h001);
    for (int i = 0; i < 4; i++) drive(0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
